// File: rtl/stepper_track_pkg.sv
// Shared types and helpers for the stepper tracking controller: channel state encoding,
// the work/product widths of the rate datapath and the output saturation helper.
package stepper_track_pkg;

    typedef enum logic [1:0] {
        STARTING   = 2'd0,
        TO_ZERO    = 2'd1,
        LEAVING_DZ = 2'd2
    } trackState_t;

    localparam int TR_WIDTH_WORK = 16;
    localparam int TR_PROD_W     = 2 * TR_WIDTH_WORK;
    localparam int TR_SAT_W      = TR_PROD_W + 1;

    // Clamp an unsigned rate to the largest value representable in 'width' bits.
    function automatic logic [TR_SAT_W-1:0] saturate(input logic [TR_SAT_W-1:0] value,
                                                     input int unsigned         width);
        logic [TR_SAT_W-1:0] maxValue;
        maxValue = {TR_SAT_W{1'b1}} >> (TR_SAT_W - width);
        return (value > maxValue) ? maxValue : value;
    endfunction

endpackage

// File: rtl/stepper_rate_calc.sv
// Channel-agnostic three-stage rate datapath: |x-x0| and direction, piecewise-linear segment
// selection, then final rate with saturation. The channel tag only travels alongside the data.
module stepper_rate_calc
    import stepper_track_pkg::*;
#(
    parameter int CH_W       = 1,
    parameter int WIDTH_WORK = TR_WIDTH_WORK,
    parameter int PERIOD_W   = 16,
    parameter int SHIFT_L    = 4,
    parameter int DZ_OUT     = 50
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [CH_W-1:0]       i_ch,
    input  logic [WIDTH_WORK-1:0] i_x,
    input  logic [WIDTH_WORK-1:0] i_x0,
    input  logic [WIDTH_WORK-1:0] i_dx1,
    input  logic [WIDTH_WORK-1:0] i_dx2,
    input  logic [WIDTH_WORK-1:0] i_F1,
    input  logic [WIDTH_WORK-1:0] i_F2,
    input  logic [WIDTH_WORK-1:0] i_k,
    output logic                  o_valid,
    output logic [CH_W-1:0]       o_ch,
    output logic [WIDTH_WORK-1:0] o_dx,
    output logic                  o_dir,
    output logic [PERIOD_W-1:0]   o_rate
);

    localparam int PROD_W = 2 * WIDTH_WORK;
    localparam logic [WIDTH_WORK-1:0] DZ_OUT_W = WIDTH_WORK'(DZ_OUT);

    logic                  r_s0Valid;
    logic [CH_W-1:0]       r_s0Ch;
    logic [WIDTH_WORK-1:0] r_s0Dx;
    logic                  r_s0Dir;

    logic                  r_s1Valid;
    logic [CH_W-1:0]       r_s1Ch;
    logic [WIDTH_WORK-1:0] r_s1Dx;
    logic                  r_s1Dir;
    logic                  r_s1Linear;
    logic [PROD_W-1:0]     r_s1Value;

    logic                  w_dir;
    logic [WIDTH_WORK-1:0] w_dx;
    logic [WIDTH_WORK-1:0] w_segDelta;
    logic                  w_segLinear;
    logic [PROD_W-1:0]     w_segValue;
    logic [PROD_W:0]       w_rateWide;
    logic [TR_SAT_W-1:0]   w_rateSat;

    assign w_dir = (i_x <= i_x0);
    assign w_dx  = w_dir ? (i_x0 - i_x) : (i_x - i_x0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s0Valid <= 1'b0;
            r_s0Ch    <= '0;
            r_s0Dx    <= '0;
            r_s0Dir   <= 1'b0;
        end else begin
            r_s0Valid <= i_valid;
            r_s0Ch    <= i_ch;
            r_s0Dx    <= w_dx;
            r_s0Dir   <= w_dir;
        end
    end

    // Priority order keeps a misconfigured dx1 >= dx2 well defined: the linear band is just empty.
    assign w_segDelta = r_s0Dx - i_dx1;

    always_comb begin
        w_segLinear = 1'b0;
        w_segValue  = '0;
        if (r_s0Dx >= i_dx2) begin
            w_segValue = PROD_W'(i_F2);
        end else if (r_s0Dx >= i_dx1) begin
            w_segLinear = 1'b1;
            w_segValue  = PROD_W'(i_k) * PROD_W'(w_segDelta);
        end else if (r_s0Dx > DZ_OUT_W) begin
            w_segValue = PROD_W'(i_F1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1Valid  <= 1'b0;
            r_s1Ch     <= '0;
            r_s1Dx     <= '0;
            r_s1Dir    <= 1'b0;
            r_s1Linear <= 1'b0;
            r_s1Value  <= '0;
        end else begin
            r_s1Valid  <= r_s0Valid;
            r_s1Ch     <= r_s0Ch;
            r_s1Dx     <= r_s0Dx;
            r_s1Dir    <= r_s0Dir;
            r_s1Linear <= w_segLinear;
            r_s1Value  <= w_segValue;
        end
    end

    assign w_rateWide = r_s1Linear
                      ? ({1'b0, r_s1Value >> SHIFT_L} + (PROD_W+1)'(i_F1))
                      : {1'b0, r_s1Value};
    assign w_rateSat  = saturate(TR_SAT_W'(w_rateWide), PERIOD_W);

    assign o_valid = r_s1Valid;
    assign o_ch    = r_s1Ch;
    assign o_dx    = r_s1Dx;
    assign o_dir   = r_s1Dir;
    assign o_rate  = w_rateSat[PERIOD_W-1:0];

endmodule

// File: rtl/stepper_track_ctrl.sv
// Multi-channel stepper tracking controller: per-channel deadzone FSMs and output registers fed by
// one shared rate pipeline. Optional feature macro: TR_SLEW_LIMIT_EN (limits period change per update).
module stepper_track_ctrl
    import stepper_track_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int WIDTH_IN   = 12,
    parameter int WIDTH_WORK = TR_WIDTH_WORK,
    parameter int PERIOD_W   = 16,
    parameter int SHIFT_L    = 4,
    parameter int DZ_OUT     = 50,
    parameter int DZ_IN      = 2,
    parameter int MAX_STEP   = 64,
    localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NCH-1:0]            i_tr_mode_enable,
    input  logic                      i_sample_valid,
    input  logic [CH_W-1:0]           i_sample_ch,
    input  logic [WIDTH_WORK-1:0]     i_sample_x,
    input  logic [NCH*WIDTH_IN-1:0]   i_x0,
    input  logic [WIDTH_WORK-1:0]     i_dx1,
    input  logic [WIDTH_WORK-1:0]     i_dx2,
    input  logic [WIDTH_WORK-1:0]     i_F1,
    input  logic [WIDTH_WORK-1:0]     i_F2,
    input  logic [WIDTH_WORK-1:0]     i_k,
    output logic [NCH*PERIOD_W-1:0]   o_period_auto,
    output logic [NCH-1:0]            o_dir_auto,
    output logic [NCH-1:0]            o_drv_en_sm,
    output logic                      o_period_valid,
    output logic [CH_W-1:0]           o_period_ch
);

    localparam logic [WIDTH_WORK-1:0] DZ_OUT_W = WIDTH_WORK'(DZ_OUT);
    localparam logic [WIDTH_WORK-1:0] DZ_IN_W  = WIDTH_WORK'(DZ_IN);

    trackState_t           r_state [NCH];
    trackState_t           w_stateNext [NCH];
    logic [PERIOD_W-1:0]   r_period [NCH];
    logic [PERIOD_W-1:0]   w_periodNext [NCH];
    logic [NCH-1:0]        r_dir;
    logic                  r_valid;
    logic [CH_W-1:0]       r_ch;

    logic [WIDTH_WORK-1:0] w_x0Sel;
    logic                  w_s2Valid;
    logic [CH_W-1:0]       w_s2Ch;
    logic [WIDTH_WORK-1:0] w_s2Dx;
    logic                  w_s2Dir;
    logic [PERIOD_W-1:0]   w_s2Rate;

    assign w_x0Sel = WIDTH_WORK'(i_x0[i_sample_ch*WIDTH_IN +: WIDTH_IN]);

    stepper_rate_calc #(
        .CH_W       (CH_W),
        .WIDTH_WORK (WIDTH_WORK),
        .PERIOD_W   (PERIOD_W),
        .SHIFT_L    (SHIFT_L),
        .DZ_OUT     (DZ_OUT)
    ) u_rateCalc (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_sample_valid),
        .i_ch    (i_sample_ch),
        .i_x     (i_sample_x),
        .i_x0    (w_x0Sel),
        .i_dx1   (i_dx1),
        .i_dx2   (i_dx2),
        .i_F1    (i_F1),
        .i_F2    (i_F2),
        .i_k     (i_k),
        .o_valid (w_s2Valid),
        .o_ch    (w_s2Ch),
        .o_dx    (w_s2Dx),
        .o_dir   (w_s2Dir),
        .o_rate  (w_s2Rate)
    );

`ifdef TR_SLEW_LIMIT_EN
    localparam logic [PERIOD_W:0] STEP_W = (PERIOD_W+1)'(MAX_STEP);

    // Move at most MAX_STEP toward the target; the target is already saturated, so no wrap.
    function automatic logic [PERIOD_W-1:0] slewStep(input logic [PERIOD_W-1:0] oldValue,
                                                     input logic [PERIOD_W-1:0] target);
        logic [PERIOD_W:0] oldExt;
        logic [PERIOD_W:0] tgtExt;
        logic [PERIOD_W:0] result;
        oldExt = {1'b0, oldValue};
        tgtExt = {1'b0, target};
        if (tgtExt > oldExt + STEP_W) begin
            result = oldExt + STEP_W;
        end else if (tgtExt + STEP_W < oldExt) begin
            result = oldExt - STEP_W;
        end else begin
            result = tgtExt;
        end
        return result[PERIOD_W-1:0];
    endfunction
`endif

    // A disabled channel is parked in STARTING with period 0 every cycle, sample or not.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            w_stateNext[c]  = r_state[c];
            w_periodNext[c] = r_period[c];
            if (!i_tr_mode_enable[c]) begin
                w_stateNext[c]  = STARTING;
                w_periodNext[c] = '0;
            end else if (w_s2Valid && (w_s2Ch == CH_W'(c))) begin
`ifdef TR_SLEW_LIMIT_EN
                w_periodNext[c] = (r_state[c] == STARTING) ? w_s2Rate
                                                           : slewStep(r_period[c], w_s2Rate);
`else
                w_periodNext[c] = w_s2Rate;
`endif
                case (r_state[c])
                    STARTING:   w_stateNext[c] = TO_ZERO;
                    TO_ZERO:    if (w_s2Dx <= DZ_IN_W)  w_stateNext[c] = LEAVING_DZ;
                    LEAVING_DZ: if (w_s2Dx >= DZ_OUT_W) w_stateNext[c] = TO_ZERO;
                    default:    w_stateNext[c] = STARTING;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int c = 0; c < NCH; c++) begin
                r_state[c]  <= STARTING;
                r_period[c] <= '0;
            end
            r_dir   <= '0;
            r_valid <= 1'b0;
            r_ch    <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                r_state[c]  <= w_stateNext[c];
                r_period[c] <= w_periodNext[c];
            end
            r_valid <= w_s2Valid;
            if (w_s2Valid) begin
                r_ch          <= w_s2Ch;
                r_dir[w_s2Ch] <= w_s2Dir;
            end
        end
    end

    always_comb begin
        o_period_auto = '0;
        o_drv_en_sm   = '0;
        for (int c = 0; c < NCH; c++) begin
            o_period_auto[c*PERIOD_W +: PERIOD_W] = r_period[c];
            o_drv_en_sm[c] = (r_state[c] == TO_ZERO);
        end
    end

    assign o_dir_auto     = r_dir;
    assign o_period_valid = r_valid;
    assign o_period_ch    = r_ch;

endmodule

// File: tb/tb_stepper_track_ctrl.sv
// Scoreboard bench for stepper_track_ctrl: a 16-bit-period and an 8-bit-period instance share the
// stimulus; expected results are queued when a sample is driven and popped when period_valid pulses.
module tb_stepper_track_ctrl;

    localparam int NCH    = 2;
    localparam int X0_VAL = 2000;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  trEnable;
    logic        sampleValid;
    logic        sampleCh;
    logic [15:0] sampleX;
    logic [23:0] x0;
    logic [15:0] dx1, dx2, F1, F2, k;

    logic [31:0] period16;
    logic [1:0]  dir16, drv16;
    logic        pv16, pch16;
    logic [15:0] period8;
    logic [1:0]  dir8, drv8;
    logic        pv8, pch8;

    typedef struct {
        int     ch;
        longint p16;
        longint p8;
        int     dir;
        int     drv;
        int     cycle;
    } expect_t;

    expect_t sb[$];
    int      nChecks = 0;
    int      nFails  = 0;
    int      cyc     = 0;
    int      mState [NCH];
    longint  mP16 [NCH];
    longint  mP8 [NCH];

    stepper_track_ctrl #(.NCH(2), .PERIOD_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_tr_mode_enable(trEnable),
        .i_sample_valid(sampleValid), .i_sample_ch(sampleCh), .i_sample_x(sampleX),
        .i_x0(x0), .i_dx1(dx1), .i_dx2(dx2), .i_F1(F1), .i_F2(F2), .i_k(k),
        .o_period_auto(period16), .o_dir_auto(dir16), .o_drv_en_sm(drv16),
        .o_period_valid(pv16), .o_period_ch(pch16)
    );

    stepper_track_ctrl #(.NCH(2), .PERIOD_W(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_tr_mode_enable(trEnable),
        .i_sample_valid(sampleValid), .i_sample_ch(sampleCh), .i_sample_x(sampleX),
        .i_x0(x0), .i_dx1(dx1), .i_dx2(dx2), .i_F1(F1), .i_F2(F2), .i_k(k),
        .o_period_auto(period8), .o_dir_auto(dir8), .o_drv_en_sm(drv8),
        .o_period_valid(pv8), .o_period_ch(pch8)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        nChecks++;
        if (observed != expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    function automatic longint modelRate(input longint dx);
        longint d1, d2, f1, f2, kk;
        d1 = dx1; d2 = dx2; f1 = F1; f2 = F2; kk = k;
        if (dx >= d2)      return f2;
        else if (dx >= d1) return ((kk * (dx - d1)) / 16) + f1;
        else if (dx > 50)  return f1;
        else               return 0;
    endfunction

    function automatic longint slewModel(input longint oldValue, input longint target);
        if (target > oldValue + 64) return oldValue + 64;
        if (target < oldValue - 64) return oldValue - 64;
        return target;
    endfunction

    task automatic applyStimulus(input int ch, input int x);
        expect_t e;
        longint  dx;
        longint  r;
        @(negedge clk);
        sampleValid = 1'b1;
        sampleCh    = 1'(ch);
        sampleX     = 16'(x);
        dx = (x > X0_VAL) ? (x - X0_VAL) : (X0_VAL - x);
        r  = modelRate(dx);
        e.ch    = ch;
        e.dir   = (x <= X0_VAL) ? 1 : 0;
        e.cycle = cyc + 3;
        if (!trEnable[ch]) begin
            mState[ch] = 0;
            e.p16 = 0;
            e.p8  = 0;
        end else begin
            e.p16 = (r > 65535) ? 65535 : r;
            e.p8  = (r > 255) ? 255 : r;
`ifdef TR_SLEW_LIMIT_EN
            if (mState[ch] != 0) begin
                e.p16 = slewModel(mP16[ch], e.p16);
                e.p8  = slewModel(mP8[ch], e.p8);
            end
`endif
            case (mState[ch])
                0:       mState[ch] = 1;
                1:       if (dx <= 2)  mState[ch] = 2;
                2:       if (dx >= 50) mState[ch] = 1;
                default: mState[ch] = 0;
            endcase
        end
        mP16[ch] = e.p16;
        mP8[ch]  = e.p8;
        e.drv    = (mState[ch] == 1) ? 1 : 0;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sampleValid = 1'b0;
        end
    endtask

    task automatic setEnable(input int ch, input logic val);
        @(negedge clk);
        sampleValid  = 1'b0;
        trEnable[ch] = val;
        if (!val) begin
            mState[ch] = 0;
            mP16[ch]   = 0;
            mP8[ch]    = 0;
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_period16"}, period16, 0);
        checkOutput({tag, "_period8"}, period8, 0);
        checkOutput({tag, "_dir"}, dir16, 0);
        checkOutput({tag, "_drv"}, drv16, 0);
        checkOutput({tag, "_valid"}, pv16, 0);
        checkOutput({tag, "_ch"}, pch16, 0);
    endtask

    // Monitor: pop one expectation per period_valid pulse and compare both instances.
    initial begin
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (pv16) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("latency", cyc, e.cycle);
                    checkOutput("period_ch", pch16, e.ch);
                    checkOutput("period16", period16[e.ch*16 +: 16], e.p16);
                    checkOutput("dir", dir16[e.ch], e.dir);
                    checkOutput("drv_en", drv16[e.ch], e.drv);
                    checkOutput("valid8", pv8, 1);
                    checkOutput("period8", period8[e.ch*8 +: 8], e.p8);
                end
            end else if (pv8) begin
                checkOutput("unexpected_valid8", 1, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int c = 0; c < NCH; c++) begin
            mState[c] = 0;
            mP16[c]   = 0;
            mP8[c]    = 0;
        end
        rst         = 1'b1;
        trEnable    = 2'b00;
        sampleValid = 1'b0;
        sampleCh    = 1'b0;
        sampleX     = 16'd0;
        x0          = {12'd2000, 12'd2000};
        dx1 = 16'd100; dx2 = 16'd1000; F1 = 16'd200; F2 = 16'd3000; k = 16'd32;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;

        $display("[TB] single sample, dx=500 on ch0");
        setEnable(0, 1'b1);
        applyStimulus(0, 2500);
        idle(5);

        $display("[TB] deadzone hysteresis on ch0");
        applyStimulus(0, 2500);
        applyStimulus(0, 2002);
        applyStimulus(0, 2040);
        applyStimulus(0, 2049);
        applyStimulus(0, 2050);
        idle(5);

        $display("[TB] interleaved channels, one sample per cycle");
        setEnable(1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 3200);
            applyStimulus(1, 1940);
        end
        idle(5);
        checkOutput("xtalk_p0", period16[15:0], 3000);
        checkOutput("xtalk_p1", period16[31:16], 200);
        checkOutput("xtalk_dir1", dir16[1], 1);
        checkOutput("xtalk_dir0", dir16[0], 0);
        checkOutput("sat8_p0", period8[7:0], 255);
        checkOutput("sat8_p1", period8[15:8], 200);

        $display("[TB] disable ch1 while ch0 stays active");
        setEnable(1, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("dis_drv1", drv16[1], 0);
        checkOutput("dis_p1", period16[31:16], 0);
        checkOutput("dis_p1_8", period8[15:8], 0);
        checkOutput("dis_drv0_kept", drv16[0], 1);
        checkOutput("dis_p0_kept", period16[15:0], 3000);
        applyStimulus(1, 1940);
        applyStimulus(0, 3200);
        applyStimulus(1, 2300);
        idle(5);

        $display("[TB] misconfigured segment, dx1 above dx2");
        dx1 = 16'd1000; dx2 = 16'd100;
        applyStimulus(0, 2500);
        applyStimulus(0, 2080);
        applyStimulus(0, 2030);
        idle(5);
        dx1 = 16'd100; dx2 = 16'd1000;

        $display("[TB] large period step on ch0");
        applyStimulus(0, 2500);
        applyStimulus(0, 1940);
        applyStimulus(0, 1940);
        idle(5);

        $display("[TB] reset with samples in flight");
        applyStimulus(0, 2500);
        applyStimulus(0, 2600);
        @(negedge clk);
        sampleX = 16'd2700;
        rst     = 1'b1;
        sb.delete();
        for (int c = 0; c < NCH; c++) begin
            mState[c] = 0;
            mP16[c]   = 0;
            mP8[c]    = 0;
        end
        idle(2);
        rst = 1'b0;
        idle(6);
        checkAllZero("post_reset");

        applyStimulus(0, 2500);
        idle(6);
        checkOutput("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
